// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single-port, synchronous-read data memory between the pipeline
//   MEM stage and a debug scanner. A rising edge on the scan button starts a
//   scan of SCAN_WORDS consecutive words starting at SCAN_BASE. The addresses
//   wrap modulo 2^ADDR_W. Each scanned word is presented on o_dbg_* with a
//   one-cycle o_dbg_valid pulse. The pipeline always has priority. The scanner
//   only uses cycles in which the pipeline makes no request.
//
// Optional feature (macro DMEM_ARB_STARVE_GUARD_EN):
//   When the macro is defined, a wait counter tracks consecutive ISSUE cycles
//   lost to the pipeline. When the counter reaches MAX_WAIT, the next ISSUE
//   cycle becomes a forced debug grant, and o_stall=1 for that single cycle.
//   When the macro is undefined, o_stall is tied to 0 and the scanner waits
//   for as long as the pipeline keeps requesting.
//
// Ports:
//   i_clk               system clock, rising edge
//   i_rst               asynchronous active-low reset
//   i_btn_enable_d_s_o  scan-start button (synchronous), rising edge starts
//   i_pl_req/we/be/addr/wdata   pipeline memory request
//   o_pl_rdata          read data to the pipeline (memory data passed through)
//   o_stall             pipeline must hold MEM stage this cycle
//   o_mem_en/we/be/addr/wdata   memory port
//   i_mem_rdata         memory read data (one cycle after a read)
//   o_dbg_valid         one-cycle pulse: o_dbg_addr/o_dbg_data hold a word
//   o_dbg_addr/data     scanned word and its address
//   o_dbg_busy          a scan is in progress
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int SCAN_BASE  = 0,
    parameter int SCAN_WORDS = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_btn_enable_d_s_o,
    input  logic              i_pl_req,
    input  logic              i_pl_we,
    input  logic [3:0]        i_pl_be,
    input  logic [ADDR_W-1:0] i_pl_addr,
    input  logic [31:0]       i_pl_wdata,
    output logic [31:0]       o_pl_rdata,
    output logic              o_stall,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_dbg_valid,
    output logic [ADDR_W-1:0] o_dbg_addr,
    output logic [31:0]       o_dbg_data,
    output logic              o_dbg_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Truncating the base to ADDR_W bits makes BASE+idx wrap naturally.
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(SCAN_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SCAN_WORDS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_scan_addr;
    logic                r_btn_q;
    logic                r_dbg_valid;
    logic [ADDR_W-1:0]   r_dbg_addr;
    logic [31:0]         r_dbg_data;
    logic                r_dbg_busy;

    logic                w_start;
    logic                w_force;
    logic                w_dbg_gnt;
    logic [ADDR_W-1:0]   w_scan_addr;

    assign w_start     = i_btn_enable_d_s_o & ~r_btn_q;
    assign w_scan_addr = BASE_ADDR + r_idx;
    assign w_dbg_gnt   = (r_state == ST_ISSUE) && (!i_pl_req || w_force);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait;

    // The counter never passes MAX_WAIT: reaching it forces a grant, and a
    // grant clears the counter.
    assign w_force = (r_state == ST_ISSUE) && (r_wait == WAIT_W'(MAX_WAIT));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wait <= '0;
        end else if ((r_state == ST_ISSUE) && !w_dbg_gnt) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end
`else
    // MAX_WAIT only matters when the starvation guard is built.
    logic w_unused_max_wait;
    assign w_unused_max_wait = (MAX_WAIT > 0);
    assign w_force = 1'b0;
`endif

    // The forced grant is decoded from registered state only.
    assign o_stall = w_force;

    // Grant mux. While reset is asserted, the enables are gated off so that
    // nothing is written to memory, whatever the pipeline inputs are.
    always_comb begin
        o_mem_en    = i_pl_req;
        o_mem_we    = i_pl_we;
        o_mem_be    = i_pl_be;
        o_mem_addr  = i_pl_addr;
        o_mem_wdata = i_pl_wdata;
        if (w_dbg_gnt) begin
            o_mem_en   = 1'b1;
            o_mem_we   = 1'b0;
            o_mem_be   = 4'hF;
            o_mem_addr = w_scan_addr;
        end
        if (!i_rst) begin
            o_mem_en = 1'b0;
            o_mem_we = 1'b0;
        end
    end

    assign o_pl_rdata = i_mem_rdata;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_scan_addr <= '0;
            r_btn_q     <= 1'b0;
            r_dbg_valid <= 1'b0;
            r_dbg_addr  <= '0;
            r_dbg_data  <= '0;
            r_dbg_busy  <= 1'b0;
        end else begin
            r_btn_q     <= i_btn_enable_d_s_o;
            r_dbg_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_ISSUE;
                        r_idx      <= '0;
                        r_dbg_busy <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (w_dbg_gnt) begin
                        r_scan_addr <= w_scan_addr;
                        r_state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // The read was issued last cycle, so i_mem_rdata now holds it.
                    r_dbg_data  <= i_mem_rdata;
                    r_dbg_addr  <= r_scan_addr;
                    r_dbg_valid <= 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state    <= ST_IDLE;
                        r_dbg_busy <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dbg_valid = r_dbg_valid;
    assign o_dbg_addr  = r_dbg_addr;
    assign o_dbg_data  = r_dbg_data;
    assign o_dbg_busy  = r_dbg_busy;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    localparam int AW        = 10;
    localparam int WORDS     = 4;
    localparam int WRAP_BASE = 1022;
    localparam int MAXW      = 8;

    logic          clk;
    logic          rst_n;
    logic          btn;
    logic          pl_req;
    logic          pl_we;
    logic [3:0]    pl_be;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_wdata;

    logic [31:0]   a_pl_rdata, a_mem_wdata, a_mem_rdata, a_dbg_data;
    logic          a_stall, a_mem_en, a_mem_we, a_dbg_valid, a_dbg_busy;
    logic [3:0]    a_mem_be;
    logic [AW-1:0] a_mem_addr, a_dbg_addr;

    logic [31:0]   b_pl_rdata, b_mem_wdata, b_mem_rdata, b_dbg_data;
    logic          b_stall, b_mem_en, b_mem_we, b_dbg_valid, b_dbg_busy;
    logic [3:0]    b_mem_be;
    logic [AW-1:0] b_mem_addr, b_dbg_addr;

    logic [31:0] mem_a  [0:1023];
    logic [31:0] mem_b  [0:1023];
    logic [31:0] shadow [0:1023];

    int checks;
    int errors;

    dmem_port_arbiter #(.ADDR_W(AW), .SCAN_BASE(0), .SCAN_WORDS(WORDS), .MAX_WAIT(MAXW)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_btn_enable_d_s_o(btn),
        .i_pl_req(pl_req), .i_pl_we(pl_we), .i_pl_be(pl_be), .i_pl_addr(pl_addr), .i_pl_wdata(pl_wdata),
        .o_pl_rdata(a_pl_rdata), .o_stall(a_stall),
        .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_be(a_mem_be), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata),
        .o_dbg_valid(a_dbg_valid), .o_dbg_addr(a_dbg_addr), .o_dbg_data(a_dbg_data), .o_dbg_busy(a_dbg_busy)
    );

    dmem_port_arbiter #(.ADDR_W(AW), .SCAN_BASE(WRAP_BASE), .SCAN_WORDS(WORDS), .MAX_WAIT(MAXW)) u_dut_wrap (
        .i_clk(clk), .i_rst(rst_n), .i_btn_enable_d_s_o(btn),
        .i_pl_req(pl_req), .i_pl_we(pl_we), .i_pl_be(pl_be), .i_pl_addr(pl_addr), .i_pl_wdata(pl_wdata),
        .o_pl_rdata(b_pl_rdata), .o_stall(b_stall),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_be(b_mem_be), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata),
        .o_dbg_valid(b_dbg_valid), .o_dbg_addr(b_dbg_addr), .o_dbg_data(b_dbg_data), .o_dbg_busy(b_dbg_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous-read memories, one per instance.
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_mem_be[b]) mem_a[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            end
            a_mem_rdata <= mem_a[a_mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (b_mem_be[b]) mem_b[b_mem_addr][8*b +: 8] <= b_mem_wdata[8*b +: 8];
            end
            b_mem_rdata <= mem_b[b_mem_addr];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic press();
        @(negedge clk);
        btn    = 1'b1;
        pl_req = 1'b0;
        pl_we  = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_req   = 1'b1;
        pl_we    = 1'b1;
        pl_be    = 4'hF;
        pl_addr  = addr;
        pl_wdata = data;
        shadow[addr] = data;
        @(negedge clk);
        pl_req = 1'b0;
        pl_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 1'b0;
        pl_req = 1'b1; pl_we = 1'b1; pl_be = 4'hA; pl_addr = 10'd77; pl_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (a_dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_dbg_valid); end
        checks++; if (a_dbg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_dbg_busy); end
        checks++; if (a_dbg_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", a_dbg_addr); end
        checks++; if (a_dbg_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_dbg_data); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", a_stall); end
        checks++; if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_en_we: got en=%b we=%b want 0 0", a_mem_en, a_mem_we); end
        checks++; if (a_mem_addr !== 10'd77 || a_mem_be !== 4'hA || a_mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL reset_mux: got addr=%0d be=%h wd=%h want 77 a 12345678", a_mem_addr, a_mem_be, a_mem_wdata); end
        checks++; if (b_dbg_busy !== 1'b0) begin errors++; $display("FAIL reset_wrap_busy: got %b want 0", b_dbg_busy); end
        @(negedge clk);
        rst_n = 1'b1; pl_req = 1'b0; pl_we = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic exp_v, exp_busy, exp_en;
        int k;
        write_word(10'd0, 32'h1111_1111);
        write_word(10'd1, 32'h2222_2222);
        write_word(10'd2, 32'h3333_3333);
        write_word(10'd3, 32'h4444_4444);
        write_word(10'd1022, 32'hAAAA_0001);
        write_word(10'd1023, 32'hAAAA_0002);
        press();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); btn = 1'b0; #1;
            exp_v    = (c >= 2) && (c <= 8) && ((c % 2) == 0);
            exp_busy = (c < 8);
            exp_en   = (c <= 6) && ((c % 2) == 0);
            k        = (c - 2) / 2;
            checks++; if (a_dbg_valid !== exp_v) begin
                errors++; $display("FAIL idle_valid c=%0d: got %b want %b", c, a_dbg_valid, exp_v); end
            if (exp_v) begin
                checks++; if (a_dbg_addr !== AW'(k) || a_dbg_data !== shadow[k]) begin
                    errors++; $display("FAIL idle_word c=%0d: got %0d/%h want %0d/%h", c, a_dbg_addr, a_dbg_data, k, shadow[k]); end
            end
            checks++; if (a_dbg_busy !== exp_busy) begin
                errors++; $display("FAIL idle_busy c=%0d: got %b want %b", c, a_dbg_busy, exp_busy); end
            checks++; if (a_mem_en !== exp_en || (exp_en && (a_mem_addr !== AW'(c / 2) || a_mem_we !== 1'b0 || a_mem_be !== 4'hF))) begin
                errors++; $display("FAIL idle_mem c=%0d: got en=%b addr=%0d we=%b be=%h want en=%b addr=%0d", c, a_mem_en, a_mem_addr, a_mem_we, a_mem_be, exp_en, c / 2); end
        end
    endtask

    task automatic test_addr_wrap();
        logic exp_v;
        int k, ea;
        press();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); btn = 1'b0; #1;
            exp_v = (c >= 2) && (c <= 8) && ((c % 2) == 0);
            k     = (c - 2) / 2;
            ea    = (WRAP_BASE + k) % 1024;
            checks++; if (b_dbg_valid !== exp_v) begin
                errors++; $display("FAIL wrap_valid c=%0d: got %b want %b", c, b_dbg_valid, exp_v); end
            if (exp_v) begin
                checks++; if (b_dbg_addr !== AW'(ea) || b_dbg_data !== shadow[ea]) begin
                    errors++; $display("FAIL wrap_word c=%0d: got %0d/%h want %0d/%h", c, b_dbg_addr, b_dbg_data, ea, shadow[ea]); end
            end
        end
    endtask

    task automatic test_pl_priority();
        int n;
        press();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            btn = 1'b0; pl_req = 1'b1; pl_we = 1'b1; pl_be = 4'hF; pl_addr = 10'd2; pl_wdata = 32'hCAFE_F00D;
            #1;
            checks++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_addr !== 10'd2 || a_mem_wdata !== 32'hCAFE_F00D) begin
                errors++; $display("FAIL prio_mux c=%0d: got en=%b we=%b addr=%0d wd=%h want 1 1 2 cafef00d", c, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata); end
            checks++; if (a_stall !== 1'b0 || a_dbg_valid !== 1'b0 || a_dbg_busy !== 1'b1) begin
                errors++; $display("FAIL prio_state c=%0d: got stall=%b valid=%b busy=%b want 0 0 1", c, a_stall, a_dbg_valid, a_dbg_busy); end
        end
        shadow[2] = 32'hCAFE_F00D;
        n = 0;
        for (int c = 0; c < 40 && n < WORDS; c++) begin
            @(negedge clk); pl_req = 1'b0; pl_we = 1'b0; #1;
            checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b want 0", a_stall); end
            if (a_dbg_valid) begin
                checks++; if (a_dbg_addr !== AW'(n) || a_dbg_data !== shadow[n]) begin
                    errors++; $display("FAIL prio_word %0d: got %0d/%h want %0d/%h", n, a_dbg_addr, a_dbg_data, n, shadow[n]); end
                n++;
            end
        end
        checks++; if (n != WORDS) begin errors++; $display("FAIL prio_count: got %0d want %0d", n, WORDS); end
        checks++; if (a_dbg_busy !== 1'b0) begin errors++; $display("FAIL prio_busy_end: got %b want 0", a_dbg_busy); end
    endtask

    task automatic test_starvation();
        int n;
        press();
`ifdef DMEM_ARB_STARVE_GUARD_EN
        n = 0;
        for (int c = 0; c <= 20; c++) begin
            logic exp_stall, exp_v;
            @(negedge clk);
            btn = 1'b0; pl_req = 1'b1; pl_we = 1'b0; pl_be = 4'hF; pl_addr = 10'd16;
            #1;
            exp_stall = (c == MAXW) || (c == 2 * MAXW + 2);
            exp_v     = (c == MAXW + 2) || (c == 2 * MAXW + 4);
            checks++; if (a_stall !== exp_stall) begin
                errors++; $display("FAIL starve_stall c=%0d: got %b want %b", c, a_stall, exp_stall); end
            checks++; if (a_dbg_valid !== exp_v) begin
                errors++; $display("FAIL starve_valid c=%0d: got %b want %b", c, a_dbg_valid, exp_v); end
            if (exp_stall) begin
                checks++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== AW'(c / (MAXW + 2))) begin
                    errors++; $display("FAIL starve_dbg_read c=%0d: got en=%b we=%b addr=%0d want 1 0 %0d", c, a_mem_en, a_mem_we, a_mem_addr, c / (MAXW + 2)); end
            end else begin
                checks++; if (a_mem_en !== 1'b1 || a_mem_addr !== 10'd16) begin
                    errors++; $display("FAIL starve_pl_fwd c=%0d: got en=%b addr=%0d want 1 16", c, a_mem_en, a_mem_addr); end
            end
            if (a_dbg_valid) n++;
        end
`else
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            btn = 1'b0; pl_req = 1'b1; pl_we = 1'b0; pl_be = 4'hF; pl_addr = 10'd16;
            #1;
            checks++; if (a_stall !== 1'b0 || a_dbg_valid !== 1'b0 || a_dbg_busy !== 1'b1) begin
                errors++; $display("FAIL starve_wait c=%0d: got stall=%b valid=%b busy=%b want 0 0 1", c, a_stall, a_dbg_valid, a_dbg_busy); end
            checks++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 10'd16) begin
                errors++; $display("FAIL starve_pl_fwd c=%0d: got en=%b we=%b addr=%0d want 1 0 16", c, a_mem_en, a_mem_we, a_mem_addr); end
        end
`endif
        for (int c = 0; c < 40 && a_dbg_busy; c++) begin
            @(negedge clk); pl_req = 1'b0; #1;
            checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL starve_release_stall: got %b want 0", a_stall); end
            if (a_dbg_valid) begin
                checks++; if (a_dbg_addr !== AW'(n) || a_dbg_data !== shadow[n]) begin
                    errors++; $display("FAIL starve_word %0d: got %0d/%h want %0d/%h", n, a_dbg_addr, a_dbg_data, n, shadow[n]); end
                n++;
            end
        end
        checks++; if (n != WORDS) begin errors++; $display("FAIL starve_count: got %0d want %0d", n, WORDS); end
    endtask

    task automatic test_random_traffic();
        logic        hold, pend;
        logic [31:0] pend_data;
        int          n, nb, ea;
        for (int a = 16; a < 32; a++) write_word(AW'(a), $urandom);
        for (int iter = 0; iter < 3; iter++) begin
            for (int k = 0; k < WORDS; k++) begin
                write_word(AW'(k), $urandom);
                write_word(AW'((WRAP_BASE + k) % 1024), $urandom);
            end
            hold = 1'b0; pend = 1'b0; pend_data = '0; n = 0; nb = 0;
            press();
            for (int c = 0; c < 400 && !(n == WORDS && nb == WORDS); c++) begin
                @(negedge clk);
                btn = 1'b0;
                if (!hold) begin
                    pl_req   = ($urandom_range(0, 99) < 60);
                    pl_we    = 1'($urandom_range(0, 1));
                    pl_be    = 4'($urandom_range(1, 15));
                    pl_addr  = AW'($urandom_range(16, 31));
                    pl_wdata = $urandom;
                end
                #1;
                if (pend) begin
                    checks++; if (a_pl_rdata !== pend_data) begin
                        errors++; $display("FAIL rand_pl_rdata: got %h want %h", a_pl_rdata, pend_data); end
                end
                pend = 1'b0;
                if (pl_req && !a_stall) begin
                    checks++; if (a_mem_en !== 1'b1 || a_mem_we !== pl_we || a_mem_addr !== pl_addr || a_mem_be !== pl_be || a_mem_wdata !== pl_wdata) begin
                        errors++; $display("FAIL rand_pl_fwd: got en=%b we=%b addr=%0d be=%h want 1 %b %0d %h", a_mem_en, a_mem_we, a_mem_addr, a_mem_be, pl_we, pl_addr, pl_be); end
                    if (pl_we) shadow[pl_addr] = merge(shadow[pl_addr], pl_wdata, pl_be);
                    else begin pend = 1'b1; pend_data = shadow[pl_addr]; end
                end
                if (a_stall) begin
                    checks++; if (a_mem_we !== 1'b0 || a_mem_en !== 1'b1) begin
                        errors++; $display("FAIL rand_stall_mux: got en=%b we=%b want 1 0", a_mem_en, a_mem_we); end
                end
`ifndef DMEM_ARB_STARVE_GUARD_EN
                checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rand_stall_off: got %b want 0", a_stall); end
`endif
                hold = pl_req && a_stall;
                if (a_dbg_valid) begin
                    $display("scan A word %0d addr=%0d data=%h", n, a_dbg_addr, a_dbg_data);
                    checks++; if (a_dbg_addr !== AW'(n) || a_dbg_data !== shadow[n]) begin
                        errors++; $display("FAIL rand_word_a %0d: got %0d/%h want %0d/%h", n, a_dbg_addr, a_dbg_data, n, shadow[n]); end
                    n++;
                end
                if (b_dbg_valid) begin
                    ea = (WRAP_BASE + nb) % 1024;
                    checks++; if (b_dbg_addr !== AW'(ea) || b_dbg_data !== shadow[ea]) begin
                        errors++; $display("FAIL rand_word_b %0d: got %0d/%h want %0d/%h", nb, b_dbg_addr, b_dbg_data, ea, shadow[ea]); end
                    nb++;
                end
            end
            checks++; if (n != WORDS || nb != WORDS) begin
                errors++; $display("FAIL rand_count iter=%0d: got %0d/%0d want %0d", iter, n, nb, WORDS); end
            @(negedge clk); pl_req = 1'b0; pl_we = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_second_press_and_reset();
        logic exp_v;
        int   n;
        n = 0;
        press();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            btn = (c == 3);
            #1;
            exp_v = (c >= 2) && (c <= 8) && ((c % 2) == 0);
            checks++; if (a_dbg_valid !== exp_v) begin
                errors++; $display("FAIL press2_valid c=%0d: got %b want %b", c, a_dbg_valid, exp_v); end
            if (a_dbg_valid) n++;
        end
        checks++; if (n != WORDS || a_dbg_busy !== 1'b0) begin
            errors++; $display("FAIL press2_count: got %0d busy=%b want %0d busy=0", n, a_dbg_busy, WORDS); end
        press();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); btn = 1'b0; #1;
        end
        checks++; if (a_dbg_valid !== 1'b1 || a_dbg_addr !== 10'd1) begin
            errors++; $display("FAIL rst_pre_pulse: got valid=%b addr=%0d want 1 1", a_dbg_valid, a_dbg_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_dbg_valid !== 1'b0 || a_dbg_addr !== '0 || a_dbg_data !== '0 || a_dbg_busy !== 1'b0 || a_stall !== 1'b0 || a_mem_en !== 1'b0) begin
            errors++; $display("FAIL rst_async: got valid=%b addr=%0d data=%h busy=%b stall=%b en=%b want all 0", a_dbg_valid, a_dbg_addr, a_dbg_data, a_dbg_busy, a_stall, a_mem_en); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            checks++; if (a_dbg_valid !== 1'b0 || a_dbg_busy !== 1'b0 || b_dbg_valid !== 1'b0) begin
                errors++; $display("FAIL rst_after c=%0d: got valid=%b busy=%b wrap_valid=%b want 0", c, a_dbg_valid, a_dbg_busy, b_dbg_valid); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; btn = 1'b0; pl_req = 1'b0; pl_we = 1'b0;
        pl_be = 4'h0; pl_addr = '0; pl_wdata = '0;
        test_reset();
        test_idle_scan();
        test_addr_wrap();
        test_pl_priority();
        test_starvation();
        test_random_traffic();
        test_second_press_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
